// File: rtl/sfifo_pack_pkg.sv
// Shared types and sizing helpers for the FIFO word packer.
package sfifo_pack_pkg;

  // RUN accepts words normally; FLUSH drains in-flight data and emits a partial beat.
  typedef enum logic {
    PK_RUN   = 1'b0,
    PK_FLUSH = 1'b1
  } pk_state_e;

  // Width needed to count 0..ratio words inclusive.
  function automatic int pk_cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/pk_obuf.sv
// Single-entry output register holding one packed beat behind a valid/ready handshake.
module pk_obuf #(
  parameter int DW    = 16,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_i,
  input  logic [DW*RATIO-1:0]   data_i,
  input  logic [RATIO-1:0]      mask_i,
  input  logic                  rdy_i,
  output logic                  vld_o,
  output logic [DW*RATIO-1:0]   data_o,
  output logic [RATIO-1:0]      mask_o,
  output logic                  free_o
);

  logic                vld_q, vld_d;
  logic [DW*RATIO-1:0] data_q, data_d;
  logic [RATIO-1:0]    mask_q, mask_d;

  // The slot can take a new beat when empty or when the held one leaves this cycle.
  assign free_o = !vld_q || rdy_i;

  // Load wins over acceptance so a new beat can follow the old one with no bubble.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    mask_d = mask_q;
    if (load_i) begin
      vld_d  = 1'b1;
      data_d = data_i;
      mask_d = mask_i;
    end else if (rdy_i) begin
      vld_d  = 1'b0;
    end
  end

  // Output beat register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign mask_o = mask_q;

endmodule

// File: rtl/sfifo_pack.sv
// Pops words from a synchronous FIFO and packs RATIO of them into one wide beat,
// with an explicit flush that emits a masked partial beat.
module sfifo_pack
  import sfifo_pack_pkg::*;
#(
  parameter int DW    = 16,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DW-1:0]         fifo_rd,
  input  logic                  pk_flush,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DW*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]      out_wmask,
  output logic                  flush_done,
  output logic                  busy
);

  localparam int            CW       = pk_cnt_w(RATIO);
  localparam logic [CW:0]   RATIO_W  = (CW+1)'(RATIO);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);

  logic [DW-1:0]       acc_q [RATIO];
  logic [DW-1:0]       acc_d [RATIO];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pend_q;
  pk_state_e           state_q, state_d;
  logic                flush_done_q, flush_done_d;

  logic                ob_free;
  logic                acc_done;
  logic                held_ld;
  logic                flush_ld;
  logic                ld;
  logic [DW*RATIO-1:0] ld_data;
  logic [RATIO-1:0]    ld_mask;

  // The last word of a beat bypasses acc and goes straight to the output register.
  assign acc_done = pend_q && (cnt_q == CNT_LAST) && ob_free;
  // A full acc that could not complete earlier leaves as soon as the output is free.
  assign held_ld  = (state_q == PK_RUN) && (cnt_q == CNT_FULL) && ob_free;
  // Flush emits whatever is held once no word is still in flight.
  assign flush_ld = (state_q == PK_FLUSH) && !pend_q && (cnt_q != '0) && ob_free;
  assign ld       = acc_done || held_ld || flush_ld;

  // Words already held plus the one in flight must leave room for the next pop.
  assign fifo_re = (state_q == PK_RUN) && !fifo_empty &&
                   ((({1'b0, cnt_q} + {{CW{1'b0}}, pend_q}) < RATIO_W) || acc_done);

  assign busy       = (cnt_q != '0) || pend_q || out_vld || (state_q != PK_RUN);
  assign flush_done = flush_done_q;

  // Assemble the beat to load: full beat with the landing word on top, or held words with unused lanes zeroed.
  always_comb begin
    ld_data = '0;
    ld_mask = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (acc_done) begin
        ld_data[i*DW +: DW] = (i == RATIO - 1) ? fifo_rd : acc_q[i];
        ld_mask[i]          = 1'b1;
      end else if (CW'(i) < cnt_q) begin
        ld_data[i*DW +: DW] = acc_q[i];
        ld_mask[i]          = 1'b1;
      end
    end
  end

  // Accumulator capture and word count.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = '0;
    end else if (pend_q) begin
      for (int i = 0; i < RATIO; i++) begin
        if (cnt_q == CW'(i)) acc_d[i] = fifo_rd;
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Flush sequencing: leave FLUSH once nothing is in flight and the held words are out.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      PK_RUN: begin
        if (pk_flush) state_d = PK_FLUSH;
      end
      PK_FLUSH: begin
        if (!pend_q && ((cnt_q == '0) || ob_free)) begin
          state_d      = PK_RUN;
          flush_done_d = 1'b1;
        end
      end
    endcase
  end

  // Control and accumulator registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      state_q      <= PK_RUN;
      flush_done_q <= 1'b0;
      for (int i = 0; i < RATIO; i++) acc_q[i] <= '0;
    end else begin
      cnt_q        <= cnt_d;
      pend_q       <= fifo_re;
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
      for (int i = 0; i < RATIO; i++) acc_q[i] <= acc_d[i];
    end
  end

  pk_obuf #(
    .DW    (DW),
    .RATIO (RATIO)
  ) u_obuf (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (ld),
    .data_i (ld_data),
    .mask_i (ld_mask),
    .rdy_i  (out_rdy),
    .vld_o  (out_vld),
    .data_o (out_data),
    .mask_o (out_wmask),
    .free_o (ob_free)
  );

endmodule

// File: tb/tb_sfifo_pack.sv
// Bench for sfifo_pack: FIFO model, stream-level reference model, directed and random traffic.
module tb_sfifo_pack;

  localparam int DW    = 16;
  localparam int RATIO = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              fifo_empty;
  logic              fifo_re;
  logic [DW-1:0]     fifo_rd;
  logic              pk_flush = 1'b0;
  logic              out_vld;
  logic              out_rdy = 1'b0;
  logic [63:0]       out_data;
  logic [RATIO-1:0]  out_wmask;
  logic              flush_done;
  logic              busy;

  sfifo_pack #(.DW(DW), .RATIO(RATIO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_rd    (fifo_rd),
    .pk_flush   (pk_flush),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_wmask  (out_wmask),
    .flush_done (flush_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic [15:0] mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr  <= 8'd0;
      fifo_rd <= '0;
    end else if (fifo_re) begin
      fifo_rd <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 8'd1;
    end
  end

  // ---------------- checking ----------------
  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Stream view: every popped word joins the current group; a group closes at RATIO
  // words or at an accepted flush, and each closed non-empty group is one beat.
  typedef struct {
    logic [63:0] d;
    logic [3:0]  m;
  } beat_t;

  logic [15:0] pushed [$];
  logic [15:0] macc [$];
  beat_t       expq [$];
  bit          in_flush = 0;
  int          outstanding = 0;
  bit          prev_hold = 0;
  logic [63:0] prev_data;
  logic [3:0]  prev_mask;

  function automatic beat_t close_group();
    beat_t b;
    b.d = '0;
    b.m = '0;
    for (int i = 0; i < macc.size(); i++) begin
      b.d[i*16 +: 16] = macc[i];
      b.m[i] = 1'b1;
    end
    return b;
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      beat_t b;
      if (prev_hold) begin
        chk("hold_vld", out_vld, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_mask", out_wmask, prev_mask);
      end
      prev_hold = out_vld && !out_rdy;
      prev_data = out_data;
      prev_mask = out_wmask;

      if (flush_done) begin
        chk("flush_done_expected", in_flush, 1);
        in_flush = 0;
      end else if (in_flush) begin
        chk("re_in_flush", fifo_re, 0);
      end

      if (out_vld && out_rdy) begin
        chk("beat_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          b = expq.pop_front();
          chk("beat_data", out_data, b.d);
          chk("beat_mask", out_wmask, b.m);
          outstanding -= $countones(out_wmask);
        end
      end

      if (fifo_re) begin
        chk("re_fifo_nonempty", pushed.size() != 0, 1);
        if (pushed.size() != 0) begin
          macc.push_back(pushed.pop_front());
          outstanding++;
          chk("capacity", outstanding <= 2*RATIO, 1);
          if (macc.size() == RATIO) begin
            expq.push_back(close_group());
            macc.delete();
          end
        end
      end

      if (pk_flush && !in_flush) begin
        if (macc.size() != 0) expq.push_back(close_group());
        macc.delete();
        in_flush = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
    pushed.push_back(v);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    wr_ptr = 8'd0;
    pk_flush = 1'b0;
    out_rdy = 1'b0;
    pushed.delete();
    macc.delete();
    expq.delete();
    in_flush = 0;
    outstanding = 0;
    prev_hold = 0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic pulse_flush();
    pk_flush = 1'b1;
    tick();
    pk_flush = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int first_re, last_re, re_n, r1, r2, fd_n, fd_at, acc_n;
    bit pv, vld_seen;

    do_reset();
    #1;
    chk("rst_fifo_re", fifo_re, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_wmask", out_wmask, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_busy", busy, 0);

    // Streaming at full rate: 8 words, ready held high.
    tick();
    out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) push(16'(i));
    first_re = -1; last_re = -1; re_n = 0; r1 = -1; r2 = -1; pv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fifo_re) begin
        if (first_re < 0) first_re = k;
        last_re = k;
        re_n++;
      end
      if (out_vld && !pv) begin
        if (r1 < 0) begin
          r1 = k;
          chk("t1_beat0", out_data, 64'h0004_0003_0002_0001);
          chk("t1_mask0", out_wmask, 4'hF);
        end else if (r2 < 0) begin
          r2 = k;
          chk("t1_beat1", out_data, 64'h0008_0007_0006_0005);
        end
      end
      pv = out_vld;
    end
    chk("t1_re_count", re_n, 8);
    chk("t1_re_span", last_re - first_re, 7);
    chk("t1_lat_first", r1 - first_re, 5);
    chk("t1_lat_second", r2 - r1, 4);
    chk("t1_drained", expq.size(), 0);

    // Backpressure: 12 words, ready low.
    tick();
    do_reset();
    for (int i = 1; i <= 12; i++) push(16'(i));
    re_n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fifo_re) re_n++;
    end
    chk("t2_pops", re_n, 8);
    chk("t2_re_low", fifo_re, 0);
    chk("t2_vld", out_vld, 1);
    chk("t2_data", out_data, 64'h0004_0003_0002_0001);
    tick();
    out_rdy = 1'b1;
    acc_n = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_vld && out_rdy) acc_n++;
    end
    chk("t2_beats", acc_n, 3);
    chk("t2_drained", expq.size(), 0);

    // Partial flush of 3 words.
    tick();
    do_reset();
    out_rdy = 1'b1;
    push(16'd1); push(16'd2); push(16'd3);
    for (int k = 0; k < 8; k++) tick();
    pulse_flush();
    push(16'd4);
    fd_n = 0; vld_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (flush_done) fd_n++;
      if (out_vld && !vld_seen) begin
        vld_seen = 1;
        chk("t3_beat", out_data, 64'h0000_0003_0002_0001);
        chk("t3_mask", out_wmask, 4'b0111);
      end
    end
    chk("t3_fd_pulses", fd_n, 1);
    chk("t3_beat_seen", vld_seen, 1);
    tick();
    pulse_flush();
    for (int k = 0; k < 10; k++) tick();
    chk("t3_drained", expq.size() + macc.size(), 0);

    // Idle flush.
    do_reset();
    out_rdy = 1'b1;
    tick();
    pulse_flush();
    fd_n = 0; fd_at = -1; vld_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (flush_done) begin
        fd_n++;
        if (fd_at < 0) fd_at = k;
      end
      if (out_vld) vld_seen = 1;
    end
    chk("t4_fd_pulses", fd_n, 1);
    chk("t4_fd_soon", (fd_at >= 0) && (fd_at <= 1), 1);
    chk("t4_no_beat", vld_seen, 0);

    // Flush in the same cycle as the second pop.
    tick();
    do_reset();
    out_rdy = 1'b1;
    push(16'd1); push(16'd2);
    tick();
    pulse_flush();
    vld_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_vld && !vld_seen) begin
        vld_seen = 1;
        chk("t5_beat", out_data, 64'h0000_0000_0002_0001);
        chk("t5_mask", out_wmask, 4'b0011);
      end
    end
    chk("t5_beat_seen", vld_seen, 1);

    // Reset in the middle of a beat.
    tick();
    do_reset();
    out_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) push(16'(16'h0100 + i));
    tick(); tick(); tick();
    rstn = 1'b0;
    wr_ptr = 8'd0;
    pushed.delete(); macc.delete(); expq.delete();
    in_flush = 0; outstanding = 0; prev_hold = 0;
    #1;
    chk("t6_re", fifo_re, 0);
    chk("t6_vld", out_vld, 0);
    chk("t6_data", out_data, 0);
    chk("t6_mask", out_wmask, 0);
    chk("t6_fd", flush_done, 0);
    chk("t6_busy", busy, 0);
    tick(); tick();
    rstn = 1'b1;
    push(16'hAAAA); push(16'hBBBB); push(16'hCCCC); push(16'hDDDD);
    vld_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_vld && !vld_seen) begin
        vld_seen = 1;
        chk("t6_beat", out_data, 64'hDDDD_CCCC_BBBB_AAAA);
        chk("t6_beat_mask", out_wmask, 4'hF);
      end
    end
    chk("t6_beat_seen", vld_seen, 1);

    // Random traffic against the stream model.
    tick();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (($urandom_range(0, 2) == 0) && (8'(wr_ptr - rd_ptr) < 8'd200))
        push(16'($urandom));
      if (((k / 60) % 2) == 1) out_rdy = ($urandom_range(0, 3) == 0);
      else                     out_rdy = ($urandom_range(0, 3) != 0);
      pk_flush = ($urandom_range(0, 24) == 0);
      tick();
    end
    pk_flush = 1'b0;
    out_rdy = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    pulse_flush();
    for (int k = 0; k < 20; k++) tick();
    chk("rnd_all_popped", pushed.size(), 0);
    chk("rnd_all_delivered", expq.size() + macc.size(), 0);
    chk("rnd_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
